// File: rtl/siso_register.sv
// ---------------------------------------------------------------------------
// siso_register
// Serial-in serial-out shift register with a parallel view of every stage
// and a saturating fill counter.
//
// Parameters
//   DEPTH        number of serial stages (1..64)
//   RESET_VALUE  value loaded into every stage on reset
//
// Ports
//   clk       in   1                 clock, rising edge active
//   rst       in   1                 synchronous active-high reset
//   sin       in   1                 serial data in, sampled every edge
//   sout      out  1                 oldest stage (q[DEPTH-1])
//   q         out  DEPTH             all stages, q[0] newest
//   fill_cnt  out  clog2(DEPTH+1)    bits shifted in since reset, saturating
//   full      out  1                 fill_cnt == DEPTH
// ---------------------------------------------------------------------------
module siso_register #(
    parameter int   DEPTH       = 4,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sin,
    output logic                         sout,
    output logic [DEPTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
    output logic                         full
);

    localparam int                CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]     FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0]     LAST_CNT = CW'(DEPTH - 1);
    localparam logic [CW-1:0]     ONE_CNT  = CW'(1);
    localparam logic [CW-1:0]     ZERO_CNT = CW'(0);

    logic [DEPTH-1:0] shift_s;

    // Next value of the stage chain; a per-bit loop keeps DEPTH=1 legal
    // without a special case (the chain then collapses to q[0] <= sin).
    always_comb begin
        shift_s    = q;
        shift_s[0] = sin;
        for (int i = 1; i < DEPTH; i++) begin
            shift_s[i] = q[i-1];
        end
    end

    // Stage chain: reset has priority, otherwise shift every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= {DEPTH{RESET_VALUE}};
        end else begin
            q <= shift_s;
        end
    end

    // Fill counter and full flag; full is updated on the same edge the
    // counter reaches DEPTH so both outputs always agree.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt <= ZERO_CNT;
            full     <= 1'b0;
        end else if (fill_cnt != FULL_CNT) begin
            fill_cnt <= fill_cnt + ONE_CNT;
            full     <= (fill_cnt == LAST_CNT);
        end else begin
            fill_cnt <= fill_cnt;
            full     <= 1'b1;
        end
    end

    // Last stage is itself a flop, so sout has no path from sin.
    assign sout = q[DEPTH-1];

endmodule

// File: tb/tb_siso_register.sv
// ---------------------------------------------------------------------------
// tb_siso_register
// Drives four instances (DEPTH 4/1/8 with RESET_VALUE 0, DEPTH 4 with
// RESET_VALUE 1) from shared clk/rst/sin. A history queue of bits sampled
// since reset is the reference: each stage, sout, fill_cnt and full of every
// instance is compared after every edge, plus directed constant checks.
// ---------------------------------------------------------------------------
module tb_siso_register;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'b0;

    logic       sout_d4, sout_d1, sout_d8, sout_r1;
    logic [3:0] q_d4, q_r1;
    logic [0:0] q_d1;
    logic [7:0] q_d8;
    logic [2:0] fill_d4, fill_r1;
    logic [0:0] fill_d1;
    logic [3:0] fill_d8;
    logic       full_d4, full_d1, full_d8, full_r1;

    int n_checks = 0;
    int n_fail   = 0;

    logic hist[$];
    int   cnt = 0;

    siso_register #(.DEPTH(4), .RESET_VALUE(1'b0)) u_d4 (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout_d4), .q(q_d4),
        .fill_cnt(fill_d4), .full(full_d4));
    siso_register #(.DEPTH(1), .RESET_VALUE(1'b0)) u_d1 (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout_d1), .q(q_d1),
        .fill_cnt(fill_d1), .full(full_d1));
    siso_register #(.DEPTH(8), .RESET_VALUE(1'b0)) u_d8 (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout_d8), .q(q_d8),
        .fill_cnt(fill_d8), .full(full_d8));
    siso_register #(.DEPTH(4), .RESET_VALUE(1'b1)) u_r1 (
        .clk(clk), .rst(rst), .sin(sin), .sout(sout_r1), .q(q_r1),
        .fill_cnt(fill_r1), .full(full_r1));

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stage contents: q[i] is the bit sampled i edges ago, or the
    // reset value if fewer than i+1 bits have arrived since reset.
    function automatic logic [63:0] exp_q(input int d, input logic rv);
        logic [63:0] v;
        v = 64'd0;
        for (int i = 0; i < d; i++) begin
            if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
            else                 v[i] = rv;
        end
        return v;
    endfunction

    function automatic logic [63:0] exp_fill(input int d);
        return (cnt < d) ? 64'(cnt) : 64'(d);
    endfunction

    task automatic check_dut(input string name, input int d, input logic rv,
                             input logic [63:0] q_obs, input logic sout_obs,
                             input logic [63:0] fill_obs, input logic full_obs);
        logic [63:0] eq;
        eq = exp_q(d, rv);
        check({name, "_q"},    q_obs, eq);
        check({name, "_sout"}, 64'(sout_obs), 64'(eq[d-1]));
        check({name, "_fill"}, fill_obs, exp_fill(d));
        check({name, "_full"}, 64'(full_obs), (cnt >= d) ? 64'd1 : 64'd0);
    endtask

    // One clock edge: drive inputs, update reference, compare all instances.
    task automatic step(input logic r, input logic s);
        rst = r;
        sin = s;
        @(posedge clk);
        #1;
        if (r) begin
            hist.delete();
            cnt = 0;
        end else begin
            hist.push_back(s);
            cnt++;
            if (hist.size() > 8) void'(hist.pop_front());
        end
        check_dut("d4", 4, 1'b0, 64'(q_d4), sout_d4, 64'(fill_d4), full_d4);
        check_dut("d1", 1, 1'b0, 64'(q_d1), sout_d1, 64'(fill_d1), full_d1);
        check_dut("d8", 8, 1'b0, 64'(q_d8), sout_d8, 64'(fill_d8), full_d8);
        check_dut("r1", 4, 1'b1, 64'(q_r1), sout_r1, 64'(fill_r1), full_r1);
    endtask

    logic [6:0] seen;
    logic [9:0] pat;

    initial begin
        // Reset for two edges.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("rst_q_d4",    64'(q_d4),    64'h0);
        check("rst_sout_d4", 64'(sout_d4), 64'h0);
        check("rst_fill_d4", 64'(fill_d4), 64'h0);
        check("rst_full_d4", 64'(full_d4), 64'h0);
        check("rst_q_r1",    64'(q_r1),    64'hF);
        check("rst_sout_r1", 64'(sout_r1), 64'h1);

        // Pattern 0,1,0,1,1,0,0,0,0,0; sout after edges 4..10 collected.
        pat  = 10'b0101100000;
        seen = 7'd0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, pat[10-k]);
            if (k >= 4) seen = {seen[5:0], sout_d4};
            if (k <= 3) check("r1_sout_hold", 64'(sout_r1), 64'h1);
        end
        check("pattern_sout_d4", 64'(seen), 64'(7'b0101100));

        // Fill counter: 1,1,1 then 0,0.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        check("fill1", 64'(fill_d4), 64'd1);
        step(1'b0, 1'b1);
        check("fill2", 64'(fill_d4), 64'd2);
        step(1'b0, 1'b1);
        check("fill3", 64'(fill_d4), 64'd3);
        check("q_0111", 64'(q_d4), 64'(4'b0111));
        check("full_lo3", 64'(full_d4), 64'h0);
        step(1'b0, 1'b0);
        check("fill4", 64'(fill_d4), 64'd4);
        check("full_hi4", 64'(full_d4), 64'h1);
        step(1'b0, 1'b0);
        check("fill_sat", 64'(fill_d4), 64'd4);

        // Mid-stream reset with sin=1 is discarded and flushes all bits.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1);
        check("q_1111", 64'(q_d4), 64'hF);
        step(1'b1, 1'b1);
        check("flush_q",    64'(q_d4),    64'h0);
        check("flush_fill", 64'(fill_d4), 64'h0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0);
            check("flush_sout", 64'(sout_d4), 64'h0);
        end

        // An unknown bit travels through untouched.
        step(1'b0, 1'bx);
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);

        // Random stream against the reference history.
        step(1'b1, 1'b0);
        for (int k = 0; k < 200; k++) step(1'b0, 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/siso_register.md
SISO_REGISTER -- requirements
Module: siso_register

Interface
REQ-001 Parameter DEPTH, default 4: number of serial stages; legal range 1..64.
REQ-002 Parameter RESET_VALUE, default 1'b0: value loaded into every stage on reset.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on rising edge only.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 sin  input  1  serial data in, sampled every rising edge while rst=0.
REQ-007 sout  output  1  serial data out = last stage, registered.
REQ-008 q  output  DEPTH  parallel view of all stages; q[0] newest, q[DEPTH-1] oldest (= sout).
REQ-009 fill_cnt  output  $clog2(DEPTH+1)  count of bits shifted in since reset, saturating at DEPTH.
REQ-010 full  output  1  high when fill_cnt == DEPTH.

Function
REQ-011 Each rising edge with rst=0 SHALL shift: q[i] <= q[i-1] for i=1..DEPTH-1, and q[0] <= sin.
REQ-012 The register SHALL shift every cycle; there is no enable and no hold state.
REQ-013 sout SHALL equal q[DEPTH-1] at all times; no combinational path from sin to any output.
REQ-014 Latency: sin sampled at edge k SHALL appear on sout after edge k+DEPTH-1 (DEPTH cycles of delay).
REQ-015 DEPTH=1: q[0] <= sin, sout = q[0]; the design SHALL behave as a single D flip-flop.
REQ-016 fill_cnt SHALL increment by 1 per non-reset edge until it reaches DEPTH, then hold.
REQ-017 full SHALL be registered-consistent with fill_cnt; it asserts on the same edge fill_cnt reaches DEPTH.
REQ-018 Once full=1, sout carries only bits sampled after reset; before that, sout carries RESET_VALUE.
REQ-019 Data SHALL be shifted without inversion, reordering or loss; bit order out equals bit order in.
REQ-020 X or Z on sin SHALL propagate as-is; no other state is affected.

Reset
REQ-021 On a rising edge with rst=1, all q bits SHALL load RESET_VALUE, fill_cnt SHALL load 0, and full SHALL load 0.
REQ-022 rst=1 SHALL take priority over shifting; sin sampled on a reset edge SHALL be discarded.
REQ-023 Reset asserted mid-stream SHALL flush all in-flight bits; the first bit after reset release is sampled on the first edge with rst=0.
REQ-024 Outputs are undefined before the first reset edge; benches SHALL apply rst for at least 1 cycle.

Verification
REQ-025 DEPTH=4, rst for 2 cycles -> q=4'b0000, sout=0, fill_cnt=0, full=0.
REQ-026 DEPTH=4, after reset drive sin=0,1,0,1,1,0,0,0,0,0 on successive edges -> sout after edges 4..10 = 0,1,0,1,1,0,0.
REQ-027 DEPTH=4, sin=1 for 3 edges then 0 -> fill_cnt=1,2,3,4,4 and full=1 from the 4th edge; q=4'b0111 after 3 edges.
REQ-028 DEPTH=4, shift in 1,1,1,1, then rst=1 for one edge with sin=1 -> q=0000, fill_cnt=0; next sin=0 edges keep sout=0.
REQ-029 DEPTH=1 and DEPTH=8, random 200-bit stream -> sout equals sin delayed by exactly DEPTH edges, checked against a reference queue.
REQ-030 RESET_VALUE=1, DEPTH=4, reset -> q=4'b1111, sout=1 until the first post-reset bit reaches the last stage.
